// File: rtl/serial_pkg.sv
// serial_pkg: shared constants for the serial bus scheduler slice.
//   BYTE_W / CNT_W : byte and bit-index widths.
//   ST_*           : FSM state encodings.
//   GNT_TX / GNT_RX: one-hot grant vector bit positions.
package serial_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_TX   = 2'd1;
    localparam state_t ST_RX   = 2'd2;
    localparam state_t ST_TURN = 2'd3;

    localparam int GNT_TX = 0;
    localparam int GNT_RX = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter with a remembered last grant.
//   clk, rst   : clock, asynchronous active-high reset
//   req[1:0]   : requests, bit GNT_TX / bit GNT_RX
//   update     : strobe to record the grant that just finished
//   upd_rx     : 1 when the finished grant was the RX requester
//   gnt[1:0]   : combinational one-hot grant
module rr_arbiter2
    import serial_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_rx,
    output logic [1:0] gnt
);

    // Resets to RX so that TX wins the first tie.
    logic last_rx_r;

    // Remember which requester was served last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_rx_r <= 1'b1;
        end else if (update) begin
            last_rx_r <= upd_rx;
        end else begin
            last_rx_r <= last_rx_r;
        end
    end

    // One-hot grant; on a tie the requester not served last wins.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_rx_r ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/serial_bus_scheduler.sv
// serial_bus_scheduler: half-duplex scheduler for a single-wire serial bus.
// Arbitrates TX/RX requesters, shifts byte bursts LSB first and inserts a
// turnaround gap between bursts.
//   clk, rst                    : clock, asynchronous active-high reset
//   tx_req, tx_data, tx_ack     : host TX byte interface
//   rx_req, rx_data, rx_valid   : host RX byte interface
//   ser_drive, ser_bit_o, ser_bit_i, ser_next_byte, count : pad-slice controls
//   busy                        : high whenever the FSM is not IDLE
module serial_bus_scheduler
    import serial_pkg::*;
#(
    parameter int MAX_BURST  = 4,
    parameter int TURNAROUND = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_req,
    input  logic [BYTE_W-1:0] tx_data,
    output logic              tx_ack,
    input  logic              rx_req,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              ser_drive,
    output logic              ser_bit_o,
    input  logic              ser_bit_i,
    output logic              ser_next_byte,
    output logic [CNT_W-1:0]  count,
    output logic              busy
);

    state_t            state_r;
    logic [BYTE_W-1:0] shift_r;
    logic [CNT_W-1:0]  count_r;
    logic [3:0]        burst_r;
    logic [2:0]        turn_r;
    logic              tx_ack_r;
    logic              rx_valid_r;
    logic [BYTE_W-1:0] rx_data_r;

    logic [1:0] gnt_s;
    logic       shifting_s;
    logic       byte_end_s;
    logic       cur_req_s;
    logic       more_s;
    logic       cont_s;
    logic       update_s;
    logic [BYTE_W-1:0] rx_next_s;

    // Decode the end-of-byte continuation decision.
    always_comb begin
        shifting_s = (state_r == ST_TX) || (state_r == ST_RX);
        byte_end_s = shifting_s && (count_r == 3'd7);
        cur_req_s  = (state_r == ST_TX) ? tx_req : rx_req;
        // burst_r counts bytes already finished in this grant, excluding the current one.
        more_s     = (burst_r < 4'(MAX_BURST - 1));
        cont_s     = cur_req_s && more_s;
        update_s   = byte_end_s && !cont_s;
        rx_next_s  = {ser_bit_i, shift_r[BYTE_W-1:1]};
    end

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({rx_req, tx_req}),
        .update (update_s),
        .upd_rx (state_r == ST_RX),
        .gnt    (gnt_s)
    );

    // Main FSM with shift register, bit, burst and turnaround counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            shift_r    <= 8'h00;
            count_r    <= 3'd0;
            burst_r    <= 4'd0;
            turn_r     <= 3'd0;
            tx_ack_r   <= 1'b0;
            rx_valid_r <= 1'b0;
            rx_data_r  <= 8'h00;
        end else begin
            tx_ack_r   <= 1'b0;
            rx_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    count_r <= 3'd0;
                    burst_r <= 4'd0;
                    if (gnt_s[GNT_TX]) begin
                        shift_r  <= tx_data;
                        tx_ack_r <= 1'b1;
                        state_r  <= ST_TX;
                    end else if (gnt_s[GNT_RX]) begin
                        shift_r  <= 8'h00;
                        state_r  <= ST_RX;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_TX, ST_RX: begin
                    if (byte_end_s) begin
                        if (state_r == ST_RX) begin
                            rx_data_r  <= rx_next_s;
                            rx_valid_r <= 1'b1;
                        end
                        count_r <= 3'd0;
                        if (cont_s) begin
                            burst_r <= burst_r + 4'd1;
                            if (state_r == ST_TX) begin
                                shift_r  <= tx_data;
                                tx_ack_r <= 1'b1;
                            end else begin
                                shift_r  <= 8'h00;
                            end
                        end else begin
                            shift_r <= 8'h00;
                            turn_r  <= 3'd0;
                            state_r <= ST_TURN;
                        end
                    end else begin
                        count_r <= count_r + 3'd1;
                        shift_r <= (state_r == ST_TX) ? (shift_r >> 1) : rx_next_s;
                    end
                end
                ST_TURN: begin
                    count_r <= 3'd0;
                    if (turn_r == 3'(TURNAROUND - 1)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        turn_r  <= turn_r + 3'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    count_r <= 3'd0;
                end
            endcase
        end
    end

    // Outputs are decoded purely from registered state.
    always_comb begin
        tx_ack        = tx_ack_r;
        rx_valid      = rx_valid_r;
        rx_data       = rx_data_r;
        count         = count_r;
        busy          = (state_r != ST_IDLE);
        ser_drive     = (state_r == ST_TX);
        ser_bit_o     = (state_r == ST_TX) && shift_r[0];
        ser_next_byte = shifting_s && (count_r == 3'd0);
    end

endmodule

// File: doc/serial_bus_scheduler.md
# serial_bus_scheduler

Half-duplex scheduler for the shared single-wire serial bus driven by the bit-serial shift slice. Arbitrates between a transmit requester and a receive requester with two-way round-robin and sequences byte-framed bursts (8 bits, LSB first). Inserts a bus turnaround gap between bursts and produces the `drive` / `next_byte` / bit-count controls for the pad-side slice. Sits between the host-side byte interfaces and the bus slice.

## Interface
- `MAX_BURST`, 4: maximum bytes per grant, legal range 1..15.
- `TURNAROUND`, 1: bus-idle cycles after each burst, legal range 1..7.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `tx_req`  in  1  level; a TX byte is available on `tx_data`.
- `tx_data`  in  8  TX byte; sampled on the edge that pulses `tx_ack`.
- `tx_ack`  out  1  one-cycle pulse: the byte was consumed on the preceding edge.
- `rx_req`  in  1  level; the receiver wants bytes.
- `rx_data`  out  8  last received byte; held until the next byte completes.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` was updated.
- `ser_drive`  out  1  1 = the slice drives the bus; 0 = bus released or sampled.
- `ser_bit_o`  out  1  TX bit to drive.
- `ser_bit_i`  in  1  bit sampled from the bus.
- `ser_next_byte`  out  1  high during bit 0 of every byte, TX and RX.
- `count`  out  3  index of the current bit, 0..7.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, TX_SHIFT, RX_SHIFT, TURN.
- IDLE behaviour:
  - Arbitrates every cycle.
  - Only one requester high: that requester is granted.
  - Both high: grant goes to the requester not granted last.
  - `last_grant` resets to RX, so TX wins the first tie.
- TX grant edge:
  - Latch `tx_data` into the shift register, clear `count` and the burst counter, enter TX_SHIFT.
  - Register `tx_ack` = 1 for the next cycle.
- TX_SHIFT:
  - `ser_drive` = 1, `ser_bit_o` = shift[0].
  - Each edge: shift right and increment `count`.
- RX_SHIFT:
  - `ser_drive` = 0.
  - Each edge: shift `ser_bit_i` into bit 7 of the shift register (LSB first) and increment `count`.
- End of byte (edge with `count` = 7):
  - RX only: `rx_data` ← assembled byte; `rx_valid` pulses in the next cycle.
  - Continue if the current requester's req is still high and fewer than `MAX_BURST` bytes have been sent in this grant. TX continuation latches the next `tx_data` and pulses `tx_ack`. No gap between bytes.
  - Otherwise enter TURN.
  - Requester drop mid-byte has no effect: a byte is never truncated.
- TURN: `ser_drive` = 0 for `TURNAROUND` cycles, then IDLE. `last_grant` is updated on entry.
- `count` wraps 7→0 only across back-to-back bytes. It is 0 in IDLE and TURN.
- Burst counter width: 4 bits.

## Timing
- Reset (async) values:
  - All outputs 0: `ser_drive`, `tx_ack`, `rx_valid`, `ser_next_byte`, `busy`, `count`, `rx_data` = 8'h00, `ser_bit_o`.
  - State is IDLE.
- Reset mid-burst: the partial byte is discarded, with no `tx_ack` or `rx_valid` afterwards. Operation resumes from IDLE on the first edge after `rst` falls.
- Grant at edge N: bits occupy cycles N+1..N+8.
  - TX: `tx_ack` is high in cycle N+1.
  - RX: `rx_valid` is high in cycle N+9.
- Requester handshake: present the next byte and deassert `tx_req` (if done) by the edge ending the `tx_ack` cycle.
- Minimum gap between bursts: `TURNAROUND` + 1 cycles (TURN plus the IDLE arbitration cycle).
- `ser_next_byte` coincides with `count` = 0 in a shift state.

## Structure
- Shared package `serial_pkg`:
  - state enum.
  - `BYTE_W` = 8.
  - `CNT_W` = 3.
- Sub-module `rr_arbiter2`: two requests, a `last_grant` register and an update strobe; combinational one-hot grant.
- Top level holds the FSM, shift register, bit counter and burst counter.

## Test plan
- Reset, then `tx_req` with `tx_data` = 8'hA5:
  - `tx_ack` in cycle N+1.
  - `ser_bit_o` sequence 1,0,1,0,0,1,0,1.
  - `ser_drive` = 1 for exactly 8 cycles, then TURN for 1 cycle.
- `rx_req` with the bus driven 0,1,1,0,1,0,0,1 (LSB first):
  - `rx_data` = 8'h96.
  - `rx_valid` is a single pulse in cycle N+9.
  - `ser_drive` stays 0 throughout.
- `tx_req` held high with 6 bytes queued, `MAX_BURST` = 4:
  - 4 back-to-back bytes, 32 bit cycles with no gaps.
  - TURN, then a new grant to TX; 2 remaining bytes sent.
- `tx_req` and `rx_req` high together from reset:
  - Order is TX burst, RX burst, TX burst.
  - Each pair of bursts is separated by `TURNAROUND` + 1 idle cycles.
- `rst` asserted at bit 3 of an RX byte:
  - Outputs go to 0 immediately, asynchronously.
  - No `rx_valid`; `rx_data` = 8'h00.
  - A new grant occurs after release.
- `tx_req` dropped during bit 5 of a byte:
  - The byte completes all 8 bits.
  - No further `tx_ack`; TURN follows.
